// File: rtl/high_bit_normalize_if.sv
// Handshake bundle for high_bit_normalize: input word/index channel and result channel.
// valid/ready: a word moves on the rising edge where valid and ready are both 1; valid and its payload hold until then.
interface high_bit_normalize_if #(
   parameter int INPUT_WIDTH = 16,
   parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [INPUT_WIDTH-1:0] in_data;
   logic [IDX_WIDTH-1:0]   in_idx;
   logic                   in_zero;
   logic                   out_valid;
   logic                   out_ready;
   logic [INPUT_WIDTH-1:0] out_mant;
   logic [IDX_WIDTH-1:0]   out_exp;
   logic                   out_zero;
   logic                   out_err;

   modport master (
      output in_valid, in_data, in_idx, in_zero, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_zero, out_err
   );

   modport slave (
      input  in_valid, in_data, in_idx, in_zero, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_zero, out_err
   );
endinterface

// File: rtl/high_bit_normalize.sv
// Left-normalizes a word so its reported highest set bit lands at the MSB; flags inconsistent indices.
// Optional macro HBN_FAST_SHIFT_EN: single-cycle barrel shift instead of the one-bit-per-cycle shifter.
module high_bit_normalize #(
   parameter int INPUT_WIDTH = 16,
   parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   high_bit_normalize_if.slave  bus,
   output logic [1:0]           dbg_state
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [IDX_WIDTH:0]   WIDTH_C = (IDX_WIDTH+1)'(INPUT_WIDTH);
   localparam logic [IDX_WIDTH-1:0] TOP_IDX = IDX_WIDTH'(INPUT_WIDTH - 1);

   logic [1:0]             state;
   logic [INPUT_WIDTH-1:0] mant;
   logic [IDX_WIDTH-1:0]   exp_r;
   logic                   zero_r;
   logic                   err_r;
   logic [IDX_WIDTH-1:0]   k;

   logic                   data_zero;
   logic                   idx_oob;
   logic                   idx_bad;
   logic [IDX_WIDTH-1:0]   k_calc;

   // A consistent index leaves exactly a single 1 once the word is shifted down by it.
   always_comb begin
      data_zero = bus.in_zero || (bus.in_data == '0);
      idx_oob   = ({1'b0, bus.in_idx} >= WIDTH_C);
      idx_bad   = ((bus.in_data >> bus.in_idx) != INPUT_WIDTH'(1));
      k_calc    = TOP_IDX - bus.in_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mant   <= '0;
         exp_r  <= '0;
         zero_r <= 1'b0;
         err_r  <= 1'b0;
         k      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (data_zero || idx_oob) begin
                     mant   <= '0;
                     exp_r  <= '0;
                     zero_r <= 1'b1;
                     err_r  <= !data_zero;
                     k      <= '0;
                     state  <= DONE;
                  end else begin
                     exp_r  <= bus.in_idx;
                     zero_r <= 1'b0;
                     err_r  <= idx_bad;
`ifdef HBN_FAST_SHIFT_EN
                     mant   <= bus.in_data << k_calc;
                     k      <= '0;
                     state  <= DONE;
`else
                     mant   <= bus.in_data;
                     k      <= k_calc;
                     state  <= (k_calc == '0) ? DONE : SHIFT;
`endif
                  end
               end
            end
            SHIFT: begin
               // Final shift happens on the edge where k goes 1 -> 0.
               mant <= mant << 1;
               k    <= k - IDX_WIDTH'(1);
               if (k == IDX_WIDTH'(1)) state <= DONE;
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_mant  = mant;
   assign bus.out_exp   = exp_r;
   assign bus.out_zero  = zero_r;
   assign bus.out_err   = err_r;
   assign dbg_state     = state;
endmodule

// File: tb/tb_high_bit_normalize.sv
// Self-checking bench for high_bit_normalize: directed vectors, back-pressure, mid-flight reset, random traffic.
module tb_high_bit_normalize;
   localparam int W  = 16;
   localparam int IW = 4;

   logic clk;
   logic rst;
   logic [1:0] dbg_state;
   int checks;
   int failures;
   logic [W+IW+1:0] exp_q[$];

   high_bit_normalize_if #(.INPUT_WIDTH(W), .IDX_WIDTH(IW)) bus ();

   high_bit_normalize #(.INPUT_WIDTH(W), .IDX_WIDTH(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: find the true MSB by scanning, normalize by plain multiplication.
   task automatic ref_model(input logic [W-1:0] data, input logic [IW-1:0] idx, input logic zf,
                            output logic [W+IW+1:0] res, output int lat);
      int msb;
      int k;
      logic [W-1:0] m;
      msb = -1;
      for (int b = 0; b < W; b++) if (data[b]) msb = b;
      if (zf || msb < 0) begin
         res = {1'b1, 1'b0, {IW{1'b0}}, {W{1'b0}}};
         lat = 1;
      end else if (int'(idx) >= W) begin
         res = {1'b1, 1'b1, {IW{1'b0}}, {W{1'b0}}};
         lat = 1;
      end else begin
         k = W - 1 - int'(idx);
         m = W'(longint'(data) * (longint'(1) << k));
         res = {1'b0, (msb != int'(idx)), idx, m};
`ifdef HBN_FAST_SHIFT_EN
         lat = 1;
`else
         lat = k + 1;
`endif
      end
   endtask

   task automatic wait_ready(input string name);
      int guard;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s in_ready_timeout got=%b want=1", name, bus.in_ready);
      end
   endtask

   task automatic accept(input logic [W-1:0] data, input logic [IW-1:0] idx, input logic zf);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_idx   = idx;
      bus.in_zero  = zf;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
      bus.in_idx   = IW'($urandom);
      bus.in_zero  = 1'($urandom);
   endtask

   // Drives one word, measures latency, compares against the queue head, then drains.
   task automatic run_txn(input logic [W-1:0] data, input logic [IW-1:0] idx, input logic zf,
                          input int hold, input string name);
      logic [W+IW+1:0] e;
      logic [W+IW+1:0] got;
      int exp_lat;
      int lat;
      ref_model(data, idx, zf, e, exp_lat);
      exp_q.push_back(e);
      wait_ready(name);
      accept(data, idx, zf);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s out_valid_timeout got=%b want=1", name, bus.out_valid);
      end else begin
         if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
         end
         checks++;
         got = {bus.out_zero, bus.out_err, bus.out_exp, bus.out_mant};
         if (got !== e) begin
            failures++;
            $display("FAIL %s result got zero=%b err=%b exp=%0d mant=%h want zero=%b err=%b exp=%0d mant=%h",
                     name, got[W+IW+1], got[W+IW], got[W+IW-1:W], got[W-1:0],
                     e[W+IW+1], e[W+IW], e[W+IW-1:W], e[W-1:0]);
         end
      end
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s drain got valid=%b ready=%b want valid=0 ready=1", name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h16DE;
      bus.in_idx    = 4'd12;
      bus.in_zero   = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_mant !== '0 ||
          bus.out_exp !== '0 || bus.out_zero !== 1'b0 || bus.out_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got valid=%b ready=%b mant=%h exp=%0d zero=%b err=%b want 0 1 0 0 0 0",
                  bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, bus.out_zero, bus.out_err);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      run_txn(16'h16DE, 4'd12, 1'b0, 0, "vec_16DE");
      run_txn(16'h87CA, 4'd15, 1'b0, 0, "vec_87CA");
      run_txn(16'h00BE, 4'd7,  1'b0, 0, "vec_00BE");
      run_txn(16'h0000, 4'd0,  1'b1, 0, "vec_zero");
      run_txn(16'h0124, 4'd9,  1'b0, 0, "vec_err_0124");
      run_txn(16'h0001, 4'd0,  1'b0, 0, "vec_lsb");
      run_txn(16'h0000, 4'd5,  1'b0, 0, "vec_data_zero");
      run_txn(16'h8001, 4'd3,  1'b0, 1, "vec_err_above");
   endtask

   task automatic test_backpressure;
      logic [W+IW+1:0] snap;
      int transfers;
      wait_ready("bp");
      accept(16'h16DE, 4'd12, 1'b0);
      repeat (10) if (bus.out_valid !== 1'b1) @(negedge clk);
      snap = {bus.out_zero, bus.out_err, bus.out_exp, bus.out_mant};
      checks++;
      if (snap !== {1'b0, 1'b0, 4'd12, 16'hB6F0}) begin
         failures++;
         $display("FAIL bp_result got=%h want=%h", snap, {1'b0, 1'b0, 4'd12, 16'hB6F0});
      end
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             {bus.out_zero, bus.out_err, bus.out_exp, bus.out_mant} !== snap) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b want valid=1 ready=0 stable",
                     i, bus.out_valid, bus.in_ready);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      transfers = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid === 1'b1) transfers++;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      checks++;
      if (transfers != 1) begin
         failures++;
         $display("FAIL bp_transfers got=%0d want=1", transfers);
      end
   endtask

   task automatic test_reset_mid_flight;
      int pulses;
      wait_ready("rst_mid");
      accept(16'h00BE, 4'd7, 1'b0);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_state got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL rst_mid_no_output got=%0d want=0", pulses);
      end
      run_txn(16'h7643, 4'd14, 1'b0, 0, "after_rst_7643");
   endtask

   task automatic test_random;
      logic [W-1:0] d;
      logic [IW-1:0] idx;
      logic zf;
      int msb;
      int mode;
      for (int n = 0; n < 40; n++) begin
         d = W'($urandom);
         if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, W - 1);
         msb = 0;
         for (int b = 0; b < W; b++) if (d[b]) msb = b;
         mode = $urandom_range(0, 9);
         idx  = (mode < 7) ? IW'(msb) : IW'($urandom);
         zf   = (mode == 9);
         if (zf) d = '0;
         run_txn(d, idx, zf, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_idx    = '0;
      bus.in_zero   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_mid_flight;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/high_bit_normalize.md
HIGH_BIT_NORMALIZE -- requirements
Module: high_bit_normalize

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16: data width in bits, minimum 2.
REQ-002 SHALL have parameter IDX_WIDTH, default $clog2(INPUT_WIDTH): index/exponent width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream word and index present.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-007 SHALL have port in_data, input, INPUT_WIDTH bits: word searched by high_bit_search.
REQ-008 SHALL have port in_idx, input, IDX_WIDTH bits: highest-set-bit index reported by high_bit_search.
REQ-009 SHALL have port in_zero, input, 1 bit: high_bit_search found no set bit.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_mant, output, INPUT_WIDTH bits: in_data left-shifted so that the index bit lands at the MSB.
REQ-013 SHALL have port out_exp, output, IDX_WIDTH bits: exponent, equal to accepted in_idx.
REQ-014 SHALL have port out_zero, output, 1 bit: result is zero.
REQ-015 SHALL have port out_err, output, 1 bit: index inconsistent with data.

Function
REQ-016 SHALL implement FSM with states IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; accept occurs on the edge where in_valid and in_ready are both 1.
REQ-018 SHALL on accept of a zero input (in_zero=1 or in_data=0) load mant=0, exp=0, zero=1, err=0, and go to DONE.
REQ-019 SHALL on accept with in_idx>=INPUT_WIDTH load mant=0, exp=0, zero=1, err=1, and go to DONE.
REQ-020 SHALL otherwise load mant=in_data, exp=in_idx, and k=INPUT_WIDTH-1-in_idx; it SHALL go to DONE if k=0, else to SHIFT.
REQ-021 SHALL set err=1 when in_data[in_idx]=0 or any bit above in_idx is 1; normalization still proceeds by k.
REQ-022 SHALL in SHIFT perform mant<=mant<<1 (zero fill) and k<=k-1 each cycle, entering DONE on the cycle the final shift occurs.
REQ-023 SHALL assert out_valid exactly k+1 rising edges after the accept edge (k=0 gives 1 edge).
REQ-024 SHALL assert out_valid only in DONE, holding out_mant/out_exp/out_zero/out_err stable until out_ready=1.
REQ-025 SHALL on the DONE edge with out_ready=1 go to IDLE; a new accept is possible no earlier than the following edge (no overlap).
REQ-026 SHALL ignore in_data, in_idx and in_zero outside the accept edge.

Reset
REQ-027 SHALL when rst=1 at an edge go to IDLE and clear out_valid, out_mant, out_exp, out_zero, out_err and k to 0, with in_ready=1 on the next cycle.
REQ-028 SHALL when reset is asserted mid-SHIFT or mid-DONE discard the in-flight result with no out_valid pulse; rst has priority over every handshake.

Configuration
REQ-029 SHALL with macro HBN_FAST_SHIFT_EN defined replace SHIFT with a single-cycle barrel shift (mant=in_data<<k at accept), giving latency 1 edge for all inputs; SHIFT is never entered.
REQ-030 SHALL with HBN_FAST_SHIFT_EN undefined use the iterative shifter of REQ-022; results are bit-identical in both builds.

Verification
REQ-031 SHALL cover: in_data=16'h16DE, in_idx=12 -> out_mant=16'hB6F0, out_exp=12, err=0, out_valid 4 edges after accept (1 with macro).
REQ-032 SHALL cover: 16'h87CA, idx=15 -> out_mant=16'h87CA, out_exp=15, latency 1; 16'h00BE, idx=7 -> 16'hBE00, exp=7, latency 9.
REQ-033 SHALL cover: in_zero=1 with in_data=0 -> out_zero=1, out_mant=0, out_exp=0, latency 1.
REQ-034 SHALL cover: 16'h0124 with idx=9 -> out_err=1, out_mant=16'h4900, exp=9.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout, exactly one transfer on release.
REQ-036 SHALL cover: rst pulsed during SHIFT of 16'h00BE -> no out_valid, in_ready=1 next cycle, next input 16'h7643, idx=14 -> 16'hEC86, exp=14.
